delay_time_controller: RTL and testbench

- Sequences the delay-line read offset for the echo effect.
- Converts a UI delay time in milliseconds to a sample count and drives the delay buffer's delay_samples input.
- Small changes glide one sample per audio tick to avoid zipper noise. Large changes mute the wet path (fade out), jump, then fade back in.
- Sits between the control/UI register block and the variable delay buffer plus wet/dry mixer, clocked on the audio clock.

---
 rtl/delay_time_controller.sv | 143 ++++++++++++++
 tb/tb_delay_time_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_time_controller.sv
// Echo delay-line offset sequencer: converts a ms request into a sample offset, then glides or fade-jumps to it.
// Latency: a target load lands in the target register on the next edge; delay/gain steps happen on sample ticks.
// Backpressure: none; a newer target_valid simply overwrites the stored target.
module delay_time_controller #(
    parameter int ADDR_WIDTH     = 16,
    parameter int MS_WIDTH       = 12,
    parameter int SAMPLES_PER_MS = 48,
    parameter int JUMP_THRESHOLD = 256,
    parameter int GAIN_WIDTH     = 16,
    parameter int GAIN_STEP      = 256,
    parameter int RESET_DELAY    = 4800
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [MS_WIDTH-1:0]   target_ms,
    input  logic                  target_valid,
    output logic [ADDR_WIDTH-1:0] delay_samples,
    output logic [GAIN_WIDTH-1:0] wet_gain,
    output logic                  busy,
    output logic [2:0]            state_out
);

    localparam int PW = MS_WIDTH + $clog2(SAMPLES_PER_MS + 1) + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] MAX_DELAY = '1;
    localparam logic [GAIN_WIDTH-1:0] GAIN_FULL = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GLIDE    = 3'd1,
        S_FADE_OUT = 3'd2,
        S_JUMP     = 3'd3,
        S_FADE_IN  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   target;
    logic [ADDR_WIDTH-1:0]   target_conv;
    logic [ADDR_WIDTH-1:0]   delay_nxt;
    logic [GAIN_WIDTH-1:0]   gain_nxt;
    logic [GAIN_WIDTH-1:0]   gain_dn;
    logic [GAIN_WIDTH-1:0]   gain_up;
    logic [GAIN_WIDTH:0]     gain_sum;
    logic [PW-1:0]           product;
    logic [ADDR_WIDTH:0]     diff;
    logic                    at_target;
    logic                    far;

    // Full-width product so large ms values clamp instead of wrapping
    always_comb begin
        product = PW'(target_ms) * PW'(SAMPLES_PER_MS);
        if (product == '0)
            target_conv = ADDR_WIDTH'(1);
        else if (product > PW'(MAX_DELAY))
            target_conv = MAX_DELAY;
        else
            target_conv = product[ADDR_WIDTH-1:0];
    end

    always_comb begin
        if (target >= delay_samples)
            diff = {1'b0, target} - {1'b0, delay_samples};
        else
            diff = {1'b0, delay_samples} - {1'b0, target};
        at_target = (diff == '0);
        far       = (diff > (ADDR_WIDTH+1)'(JUMP_THRESHOLD));
        gain_dn   = (wet_gain >= GAIN_WIDTH'(GAIN_STEP)) ? wet_gain - GAIN_WIDTH'(GAIN_STEP) : '0;
        gain_sum  = {1'b0, wet_gain} + (GAIN_WIDTH+1)'(GAIN_STEP);
        gain_up   = (gain_sum > {1'b0, GAIN_FULL}) ? GAIN_FULL : gain_sum[GAIN_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            target        <= ADDR_WIDTH'(RESET_DELAY);
            delay_samples <= ADDR_WIDTH'(RESET_DELAY);
            wet_gain      <= GAIN_FULL;
        end else begin
            delay_samples <= delay_nxt;
            wet_gain      <= gain_nxt;
            if (target_valid)
                target <= target_conv;
        end
    end

    // Decisions on any cycle; delay/gain only move on sample ticks
    always_comb begin
        state_nxt = state;
        delay_nxt = delay_samples;
        gain_nxt  = wet_gain;
        case (state)
            S_IDLE: begin
                if (!at_target)
                    state_nxt = far ? S_FADE_OUT : S_GLIDE;
            end
            S_GLIDE: begin
                if (far) begin
                    state_nxt = S_FADE_OUT;
                end else if (at_target) begin
                    state_nxt = S_IDLE;
                end else if (sample_valid) begin
                    delay_nxt = (target > delay_samples) ? delay_samples + 1'b1
                                                         : delay_samples - 1'b1;
                    if (diff == (ADDR_WIDTH+1)'(1))
                        state_nxt = S_IDLE;
                end
            end
            S_FADE_OUT: begin
                if (wet_gain == '0)
                    state_nxt = S_JUMP;
                else if (sample_valid)
                    gain_nxt = gain_dn;
            end
            S_JUMP: begin
                if (sample_valid) begin
                    delay_nxt = target;
                    state_nxt = S_FADE_IN;
                end
            end
            S_FADE_IN: begin
                if (wet_gain == GAIN_FULL)
                    state_nxt = S_IDLE;
                else if (sample_valid)
                    gain_nxt = gain_up;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        state_out = state;
    end

endmodule

// File: tb/tb_delay_time_controller.sv
// Bench for delay_time_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_delay_time_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        target_valid = 1'b0;
    logic [11:0] target_ms = '0;
    logic [15:0] delay_samples;
    logic [15:0] wet_gain;
    logic        busy;
    logic [2:0]  state_out;

    int total = 0;
    int bad = 0;

    // behavioural model: 0 idle, 1 glide, 2 fade out, 3 jump, 4 fade in
    int m_delay, m_gain, m_tgt, m_ph;

    always #5 clk = ~clk;

    delay_time_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .target_ms    (target_ms),
        .target_valid (target_valid),
        .delay_samples(delay_samples),
        .wet_gain     (wet_gain),
        .busy         (busy),
        .state_out    (state_out)
    );

    function automatic int conv(input int ms);
        int p;
        p = ms * 48;
        if (p < 1) return 1;
        if (p > 65535) return 65535;
        return p;
    endfunction

    function automatic void model_update(input bit rst, input bit tv, input int ms, input bit sv);
        int d, nt;
        if (rst) begin
            m_delay = 4800; m_gain = 65535; m_tgt = 4800; m_ph = 0;
            return;
        end
        nt = tv ? conv(ms) : m_tgt;
        d = m_tgt - m_delay;
        if (d < 0) d = -d;
        case (m_ph)
            0: if (d != 0) m_ph = (d <= 256) ? 1 : 2;
            1: begin
                if (d > 256) m_ph = 2;
                else if (d == 0) m_ph = 0;
                else if (sv) begin
                    m_delay = m_delay + ((m_tgt > m_delay) ? 1 : -1);
                    if (m_delay == m_tgt) m_ph = 0;
                end
            end
            2: if (m_gain == 0) m_ph = 3; else if (sv) m_gain = (m_gain >= 256) ? m_gain - 256 : 0;
            3: if (sv) begin m_delay = m_tgt; m_ph = 4; end
            4: if (m_gain == 65535) m_ph = 0; else if (sv) m_gain = (m_gain + 256 > 65535) ? 65535 : m_gain + 256;
            default: m_ph = 0;
        endcase
        m_tgt = nt;
    endfunction

    task automatic step(input bit rst, input bit tv, input int ms, input bit sv);
        @(negedge clk);
        reset_n      = !rst;
        target_valid = tv;
        target_ms    = ms[11:0];
        sample_valid = sv;
        @(posedge clk);
        model_update(rst, tv, ms, sv);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        total++; if (delay_samples !== 16'd4800) begin bad++; $display("FAIL reset_delay: got %0d want 4800", delay_samples); end
        total++; if (wet_gain !== 16'hFFFF) begin bad++; $display("FAIL reset_gain: got %h want ffff", wet_gain); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_out); end
        repeat (100) step(0, 0, 0, 1);
        total++; if (delay_samples !== 16'd4800) begin bad++; $display("FAIL idle_delay: got %0d want 4800", delay_samples); end
        total++; if (wet_gain !== 16'hFFFF) begin bad++; $display("FAIL idle_gain: got %h want ffff", wet_gain); end
        total++; if (busy !== 1'b0 || state_out !== 3'd0) begin bad++; $display("FAIL idle_state: got busy=%b state=%0d want 0/0", busy, state_out); end
    endtask

    task automatic test_glide();
        int n;
        step(0, 1, 102, 0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glide_load_busy: got %b want 0", busy); end
        step(0, 0, 0, 0);
        total++; if (state_out !== 3'd1) begin bad++; $display("FAIL glide_enter: got %0d want 1", state_out); end
        n = 0;
        while (busy && n < 400) begin
            step(0, 0, 0, 1);
            n++;
            total++; if (delay_samples !== 16'(4800 + n)) begin bad++; $display("FAIL glide_step: tick %0d got %0d want %0d", n, delay_samples, 4800 + n); end
            total++; if (wet_gain !== 16'hFFFF) begin bad++; $display("FAIL glide_gain: got %h want ffff", wet_gain); end
        end
        total++; if (n != 96) begin bad++; $display("FAIL glide_ticks: got %0d want 96", n); end
        total++; if (delay_samples !== 16'd4896 || state_out !== 3'd0) begin bad++; $display("FAIL glide_done: got %0d/%0d want 4896/0", delay_samples, state_out); end
    endtask

    task automatic test_fade_jump();
        int ms_tab [4]  = '{500, 4095, 0, 102};
        int exp_tab [4] = '{24000, 65535, 1, 4896};
        int prev, n;
        prev = 4896;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, ms_tab[k], 0);
            step(0, 0, 0, 0);
            total++; if (state_out !== 3'd2) begin bad++; $display("FAIL fade_enter[%0d]: got %0d want 2", k, state_out); end
            n = 0;
            while (wet_gain !== 16'h0000 && n < 600) begin
                step(0, 0, 0, 1);
                n++;
                if (n == 255) begin
                    total++; if (wet_gain !== 16'h00FF) begin bad++; $display("FAIL fade_out_255[%0d]: got %h want 00ff", k, wet_gain); end
                end
            end
            total++; if (n != 256) begin bad++; $display("FAIL fade_out_ticks[%0d]: got %0d want 256", k, n); end
            step(0, 0, 0, 0);
            total++; if (state_out !== 3'd3 || delay_samples !== 16'(prev)) begin bad++; $display("FAIL jump_enter[%0d]: got %0d/%0d want 3/%0d", k, state_out, delay_samples, prev); end
            step(0, 0, 0, 1);
            total++; if (delay_samples !== 16'(exp_tab[k])) begin bad++; $display("FAIL jump_value[%0d]: got %0d want %0d", k, delay_samples, exp_tab[k]); end
            total++; if (state_out !== 3'd4 || wet_gain !== 16'h0000) begin bad++; $display("FAIL fade_in_enter[%0d]: got %0d/%h want 4/0000", k, state_out, wet_gain); end
            n = 0;
            while (wet_gain !== 16'hFFFF && n < 600) begin
                step(0, 0, 0, 1);
                n++;
            end
            total++; if (n != 256) begin bad++; $display("FAIL fade_in_ticks[%0d]: got %0d want 256", k, n); end
            step(0, 0, 0, 0);
            total++; if (busy !== 1'b0 || state_out !== 3'd0 || delay_samples !== 16'(exp_tab[k])) begin bad++; $display("FAIL fade_done[%0d]: got busy=%b state=%0d delay=%0d want 0/0/%0d", k, busy, state_out, delay_samples, exp_tab[k]); end
            prev = exp_tab[k];
        end
    endtask

    task automatic test_retarget();
        int n;
        step(0, 1, 1000, 0);
        step(0, 0, 0, 0);
        total++; if (state_out !== 3'd2) begin bad++; $display("FAIL retarget_enter: got %0d want 2", state_out); end
        repeat (20) step(0, 0, 0, 1);
        step(0, 1, 101, 1);
        n = 0;
        while (wet_gain !== 16'h0000 && n < 600) begin step(0, 0, 0, 1); n++; end
        step(0, 0, 0, 0);
        total++; if (state_out !== 3'd3) begin bad++; $display("FAIL retarget_jump_state: got %0d want 3", state_out); end
        step(0, 0, 0, 1);
        total++; if (delay_samples !== 16'd4848) begin bad++; $display("FAIL retarget_jump_value: got %0d want 4848", delay_samples); end
        n = 0;
        while (wet_gain !== 16'hFFFF && n < 600) begin step(0, 0, 0, 1); n++; end
        step(0, 0, 0, 0);
        repeat (50) step(0, 0, 0, 1);
        total++; if (delay_samples !== 16'd4848 || busy !== 1'b0 || state_out !== 3'd0) begin bad++; $display("FAIL retarget_settle: got %0d busy=%b state=%0d want 4848/0/0", delay_samples, busy, state_out); end
    endtask

    task automatic test_reset_mid();
        int n;
        step(0, 1, 500, 0);
        step(0, 0, 0, 0);
        n = 0;
        while (wet_gain !== 16'h0000 && n < 600) begin step(0, 0, 0, 1); n++; end
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (128) step(0, 0, 0, 1);
        total++; if (wet_gain !== 16'h8000 || state_out !== 3'd4) begin bad++; $display("FAIL midfade_gain: got %h/%0d want 8000/4", wet_gain, state_out); end
        step(1, 1, 1000, 1);
        total++; if (delay_samples !== 16'd4800) begin bad++; $display("FAIL midreset_delay: got %0d want 4800", delay_samples); end
        total++; if (wet_gain !== 16'hFFFF) begin bad++; $display("FAIL midreset_gain: got %h want ffff", wet_gain); end
        total++; if (state_out !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_state: got %0d/%b want 0/0", state_out, busy); end
        repeat (20) step(0, 0, 0, 1);
        total++; if (delay_samples !== 16'd4800 || busy !== 1'b0) begin bad++; $display("FAIL midreset_no_pending: got %0d/%b want 4800/0", delay_samples, busy); end
    endtask

    task automatic test_random();
        bit rst, tv, sv;
        int ms;
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            tv  = ($urandom_range(0, 59) == 0);
            sv  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) begin
                ms = m_tgt / 48 + $urandom_range(0, 10) - 5;
                if (ms < 0) ms = 0;
                if (ms > 4095) ms = 4095;
            end else begin
                ms = $urandom_range(0, 4095);
            end
            step(rst, tv, ms, sv);
            total++; if (delay_samples !== 16'(m_delay)) begin bad++; $display("FAIL rand_delay: cyc %0d got %0d want %0d", i, delay_samples, m_delay); end
            total++; if (wet_gain !== 16'(m_gain)) begin bad++; $display("FAIL rand_gain: cyc %0d got %0d want %0d", i, wet_gain, m_gain); end
            total++; if (state_out !== 3'(m_ph)) begin bad++; $display("FAIL rand_state: cyc %0d got %0d want %0d", i, state_out, m_ph); end
            total++; if (busy !== (m_ph != 0)) begin bad++; $display("FAIL rand_busy: cyc %0d got %b want %b", i, busy, m_ph != 0); end
        end
    endtask

    initial begin
        test_reset();
        test_glide();
        test_fade_jump();
        test_retarget();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
